// File: rtl/nibble_add_seq.sv
// rtl/nibble_add_seq.sv - multi-cycle adder using one shared 4-bit ripple slice, optional SUBTRACT_EN
module nibble_add_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SUBTRACT_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int NIB = WIDTH / 4;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] partial_q, partial_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             out_valid_q, out_valid_d;

   logic [3:0]       s4;
   logic [4:0]       rc;
   logic             b_inv;

   // Operands are shifted right one nibble per RUN edge, so the active nibble is
   // always bits [3:0]; each result nibble enters partial at the top and has
   // reached its own position once all NIB nibbles are in.
   // Four chained full adders on the current nibble, carry_q in, rc[4] out.
   always_comb begin
      rc    = 5'b0;
      s4    = 4'b0;
      rc[0] = carry_q;
      for (int i = 0; i < 4; i++) begin
         s4[i]    = a_q[i] ^ b_q[i] ^ rc[i];
         rc[i+1]  = (a_q[i] & b_q[i]) | (rc[i] & (a_q[i] ^ b_q[i]));
      end
   end

   // Subtract selects inverted B with a forced carry-in of 1 (two's complement).
`ifdef SUBTRACT_EN
   assign b_inv = sub;
`else
   assign b_inv = 1'b0;
`endif

   // Next-state and datapath updates for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      a_d         = a_q;
      b_d         = b_q;
      partial_d   = partial_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d       = a;
               b_d       = b_inv ? ~b : b;
               carry_d   = b_inv ? 1'b1 : cin;
               cnt_d     = '0;
               partial_d = '0;
               state_d   = RUN;
            end
         end
         RUN: begin
            partial_d = (partial_q >> 4) | (WIDTH'(s4) << (WIDTH - 4));
            a_d       = a_q >> 4;
            b_d       = b_q >> 4;
            carry_d   = rc[4];
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == CW'(NIB - 1)) begin
               sum_d       = partial_d;
               cout_d      = rc[4];
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         partial_q   <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         a_q         <= a_d;
         b_q         <= b_d;
         partial_q   <= partial_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = rst_n && (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// tb/tb_nibble_add_seq.sv - scoreboard bench for nibble_add_seq (WIDTH=16)
module tb_nibble_add_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
`ifdef SUBTRACT_EN
   logic        sub;
`endif
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        busy;

   int          checks = 0;
   int          errors = 0;
   logic [16:0] exp_q[$];

   nibble_add_seq #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef SUBTRACT_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   function automatic logic [16:0] model(input logic [15:0] ta, input logic [15:0] tb_, input logic tc);
      logic [16:0] r;
`ifdef SUBTRACT_EN
      if (sub) r = {1'b0, ta} + {1'b0, ~tb_} + 17'd1;
      else     r = {1'b0, ta} + {1'b0, tb_} + {16'd0, tc};
`else
      r = {1'b0, ta} + {1'b0, tb_} + {16'd0, tc};
`endif
      return r;
   endfunction

   // Drive one request, push its expected result, wait for the result and handshake it.
   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                         input bit pre_ready, output logic [15:0] osum, output logic ocout,
                         output int olat, output int busy_low);
      int w;
      @(negedge clk);
      a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = pre_ready;
      w = 0;
      while (!in_ready && w < 50) begin @(negedge clk); w++; end
      olat = -1; busy_low = 0; osum = 'x; ocout = 1'bx;
      if (!in_ready) begin in_valid = 1'b0; return; end
      exp_q.push_back(model(ta, tb_, tc));
      @(negedge clk);
      in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      olat = 0;
      while (!out_valid && olat < 50) begin
         if (!busy) busy_low++;
         @(negedge clk);
         olat++;
      end
      if (!busy) busy_low++;
      osum = sum; ocout = cout;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; a = 16'h1111; b = 16'h2222; cin = 1'b0;
`ifdef SUBTRACT_EN
      sub = 1'b0;
`endif
      repeat (3) @(negedge clk);
      checks++; if (sum !== 16'h0) begin errors++; $display("FAIL reset_sum got %h want 0000", sum); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      in_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_basic;
      logic [15:0] s; logic c; int lat; int bl; logic [16:0] e;
      // T1
      run_op(16'h1234, 16'h4321, 1'b0, 1'b1, s, c, lat, bl);
      e = exp_q.pop_front();
      checks++; if ({c, s} !== 17'h05555) begin errors++; $display("FAIL t1_result got %b_%h want 0_5555", c, s); end
      checks++; if ({c, s} !== e) begin errors++; $display("FAIL t1_scoreboard got %h want %h", {c, s}, e); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL t1_latency got %0d want 4", lat); end
      checks++; if (bl !== 0) begin errors++; $display("FAIL t1_busy_low got %0d want 0", bl); end
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL t1_idle_after got ov=%b busy=%b ir=%b want 0 0 1", out_valid, busy, in_ready); end
      checks++; if (sum !== 16'h5555) begin errors++; $display("FAIL t1_sum_held got %h want 5555", sum); end
      // T2
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, c, lat, bl);
      e = exp_q.pop_front();
      checks++; if ({c, s} !== 17'h10000) begin errors++; $display("FAIL t2_result got %b_%h want 1_0000", c, s); end
      checks++; if ({c, s} !== e) begin errors++; $display("FAIL t2_scoreboard got %h want %h", {c, s}, e); end
      // T3a
      run_op(16'h0000, 16'h0000, 1'b1, 1'b0, s, c, lat, bl);
      e = exp_q.pop_front();
      checks++; if ({c, s} !== 17'h00001) begin errors++; $display("FAIL t3a_result got %b_%h want 0_0001", c, s); end
      checks++; if ({c, s} !== e) begin errors++; $display("FAIL t3a_scoreboard got %h want %h", {c, s}, e); end
      // T3b
      run_op(16'h8000, 16'h8000, 1'b0, 1'b1, s, c, lat, bl);
      e = exp_q.pop_front();
      checks++; if ({c, s} !== 17'h10000) begin errors++; $display("FAIL t3b_result got %b_%h want 1_0000", c, s); end
      checks++; if ({c, s} !== e) begin errors++; $display("FAIL t3b_scoreboard got %h want %h", {c, s}, e); end
   endtask

   task automatic test_random;
      logic [15:0] s; logic c; int lat; int bl; logic [16:0] e;
      for (int i = 0; i < 8; i++) begin
         run_op(16'($urandom), 16'($urandom), 1'($urandom), bit'(i % 2), s, c, lat, bl);
         e = exp_q.pop_front();
         checks++; if ({c, s} !== e) begin errors++; $display("FAIL rand%0d_result got %h want %h", i, {c, s}, e); end
         checks++; if (lat !== 4 || bl !== 0) begin errors++; $display("FAIL rand%0d_timing got lat=%0d busy_low=%0d want 4 0", i, lat, bl); end
      end
   endtask

   task automatic test_backpressure;
      logic [16:0] e; logic [15:0] held_s; logic held_c; int w;
      @(negedge clk);
      a = 16'h0F00; b = 16'h0123; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      w = 0;
      while (!in_ready && w < 50) begin @(negedge clk); w++; end
      exp_q.push_back(model(16'h0F00, 16'h0123, 1'b1));
      @(negedge clk);
      a = 16'h7777; b = 16'h1111; cin = 1'b0;
      w = 0;
      while (!out_valid && w < 50) begin @(negedge clk); w++; end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid got %b want 1", out_valid); end
      held_s = sum; held_c = cout;
      e = exp_q.pop_front();
      checks++; if ({held_c, held_s} !== e) begin errors++; $display("FAIL bp_first_result got %h want %h", {held_c, held_s}, e); end
      exp_q.push_back(model(16'h7777, 16'h1111, 1'b0));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || sum !== held_s || cout !== held_c) begin
            errors++; $display("FAIL bp_hold%0d got ov=%b ir=%b busy=%b sum=%h cout=%b want 1 0 1 %h %b",
                               i, out_valid, in_ready, busy, sum, cout, held_s, held_c); end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL bp_release got ov=%b ir=%b busy=%b want 0 1 0", out_valid, in_ready, busy); end
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL bp_pending_accept got busy=%b ir=%b want 1 0", busy, in_ready); end
      w = 0;
      while (!out_valid && w < 50) begin @(negedge clk); w++; end
      checks++; if (w !== 4) begin errors++; $display("FAIL bp_pending_latency got %0d want 4", w); end
      e = exp_q.pop_front();
      checks++; if ({cout, sum} !== e || {cout, sum} !== 17'h08888) begin
         errors++; $display("FAIL bp_pending_result got %h want %h", {cout, sum}, e); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic [15:0] s; logic c; int lat; int bl; logic [16:0] e; int w; int ov_seen;
      @(negedge clk);
      a = 16'hAAAA; b = 16'h1111; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin @(negedge clk); w++; end
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (sum !== 16'h0 || cout !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         errors++; $display("FAIL midreset_outputs got sum=%h cout=%b ov=%b busy=%b ir=%b want 0 0 0 0 0",
                            sum, cout, out_valid, busy, in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_release_ready got %b want 1", in_ready); end
      ov_seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid) ov_seen++;
      end
      checks++; if (ov_seen !== 0) begin errors++; $display("FAIL midreset_no_partial got %0d valid cycles want 0", ov_seen); end
      run_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, s, c, lat, bl);
      e = exp_q.pop_front();
      checks++; if ({c, s} !== 17'h01010 || {c, s} !== e) begin
         errors++; $display("FAIL t5_result got %b_%h want 0_1010", c, s); end
   endtask

`ifdef SUBTRACT_EN
   task automatic test_subtract;
      logic [15:0] s; logic c; int lat; int bl; logic [16:0] e;
      sub = 1'b1;
      run_op(16'h0007, 16'h0005, 1'b1, 1'b0, s, c, lat, bl);
      e = exp_q.pop_front();
      checks++; if ({c, s} !== 17'h10002 || {c, s} !== e) begin
         errors++; $display("FAIL t6a_result got %b_%h want 1_0002", c, s); end
      run_op(16'h0005, 16'h0007, 1'b0, 1'b0, s, c, lat, bl);
      e = exp_q.pop_front();
      checks++; if ({c, s} !== 17'h0FFFE || {c, s} !== e) begin
         errors++; $display("FAIL t6b_result got %b_%h want 0_fffe", c, s); end
      sub = 1'b0;
      run_op(16'h0005, 16'h0007, 1'b1, 1'b0, s, c, lat, bl);
      e = exp_q.pop_front();
      checks++; if ({c, s} !== 17'h0000D || {c, s} !== e) begin
         errors++; $display("FAIL t6c_add_result got %b_%h want 0_000d", c, s); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_random();
      test_backpressure();
      test_reset_mid();
`ifdef SUBTRACT_EN
      test_subtract();
`endif
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain got %0d entries want 0", exp_q.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
